fixed_point_divider: RTL
========================

# fixed_point_divider

Sequential signed fixed-point divider for the digital filter datapath, the inverse operation of the saturating Q(N/2).(N/2) multiplier. It computes Result = A / B on N-bit two's-complement operands with FRAC fractional bits. It uses a restoring shift-subtract algorithm, one quotient bit per clock. Overflow saturation and zero handling match the multiplier, so filter stages can use either block interchangeably in gain and normalisation paths.

## Interface
- N, 16, operand and result width in bits (two's complement); even, ≥ 4
- FRAC, N/2, number of fractional bits in A, B and Result
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only in IDLE
- A  input  N  dividend, signed Q format; sampled with start
- B  input  N  divisor, signed Q format; sampled with start
- busy  output  1  high while a division is in progress (state ≠ IDLE)
- done  output  1  one-cycle pulse when Result is valid
- Result  output  N  signed quotient; holds until next done
- div_zero  output  1  set with done when sampled B was zero; holds with Result

## Operation
- States: IDLE, DIVIDE, FINISH. Reset and abandoned operations return to IDLE.
- **IDLE, start=1:** latch sign = A[N-1] XOR B[N-1].
  - Latch magnitudes |A| and |B| as N-bit unsigned. 0x8000 maps to 32768.
  - Dividend register = |A| << FRAC (N+FRAC bits). Remainder = 0. Bit counter = N+FRAC. Go to DIVIDE.
- **Short path, decided in IDLE on the start edge; no DIVIDE or FINISH:**
  - B == 0 and A == 0: Result = 0, div_zero = 1, done = 1.
  - B == 0, A > 0: Result = 2^(N-1)-1, div_zero = 1, done = 1.
  - B == 0, A < 0: Result = -(2^(N-1)-1), div_zero = 1, done = 1.
  - A == 0, B ≠ 0: Result = 0, div_zero = 0, done = 1.
- **DIVIDE, per cycle:** shift MSB of dividend into remainder (N+1 bits).
  - If remainder ≥ |B|, subtract |B| and shift in quotient bit 1; otherwise shift in 0.
  - Decrement counter. At zero, go to FINISH.
- **FINISH:** Q = unsigned quotient (N+FRAC bits), truncated toward zero.
  - If Q ≥ 2^(N-1): Result = sign ? 2^(N-1)+1 (0x8001 for N=16) : 2^(N-1)-1 (0x7FFF). Negative saturation is symmetric, never 0x8000.
  - Else Result = sign ? −Q[N-1:0] : Q[N-1:0].
  - div_zero = 0, done = 1, go to IDLE.
- start is ignored while busy; A and B may change freely after the start edge.
- Reset mid-operation: the operation is abandoned, outputs take reset values, and no done is produced.

## Timing
- Reset values: busy=0, done=0, Result=0, div_zero=0, state IDLE, internal registers 0.
- Normal latency: start sampled at edge 0.
  - Edges 1..N+FRAC perform the iterations.
  - Edge N+FRAC+1 registers Result, div_zero and done (edge 25 for N=16).
- Short-path latency: Result, div_zero and done are registered on edge 0.
- busy rises after edge 0 (normal path only) and falls on the edge that asserts done.
- done is high for exactly one cycle. Back-to-back: start is accepted in the cycle done is high (state IDLE), so throughput is one division per N+FRAC+2 cycles.
- Result and div_zero change only on a done edge or on reset.

## Test plan
- **Basic:** A=0x0300 (3.0), B=0x0200 (2.0), start → Result=0x0180, div_zero=0, done exactly at edge 25, busy high edges 1..24.
- **Sign and truncation:**
  - 0xFD00 / 0x0200 → 0xFE80.
  - 0x0100 / 0x0300 → 0x0055.
  - 0xFF00 / 0x0300 → 0xFFAB.
  - 0xFF00 / 0xFD00 → 0x0055.
- **Saturation:**
  - 0x7FFF / 0x0001 → 0x7FFF.
  - 0x8000 / 0x0001 → 0x8001.
  - 0x8000 / 0xFF00 (−1.0) → 0x7FFF.
- **Zero cases:**
  - B=0, A=0x0100 → 0x7FFF, div_zero=1, done at edge 0.
  - B=0, A=0xFF00 → 0x8001, div_zero=1.
  - A=0, B=0 → 0x0000, div_zero=1.
  - A=0, B=0x0500 → 0x0000, div_zero=0.
- **Handshake:**
  - Pulse start again at edge 5 with A=0x0100, B=0x0100 → ignored; first Result unchanged.
  - Start asserted during the done cycle is accepted; its done follows 25 edges later.
- **Reset mid-op:** assert rst at edge 10 of a division → busy, done, Result and div_zero are 0 immediately. No done follows. A new start after release gives the correct result.

Source files
------------

// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider (restoring shift-subtract, one quotient bit per clock).
// Saturation and divide-by-zero handling match the saturating Q-format multiplier.
module fixed_point_divider #(
   parameter int N    = 16,
   parameter int FRAC = N / 2
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_start,
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   output logic         o_busy,
   output logic         o_done,
   output logic [N-1:0] o_result,
   output logic         o_div_zero
);

   localparam int DW = N + FRAC;
   localparam int CW = $clog2(DW + 1);

   localparam logic [N-1:0]  ZERO_N   = {N{1'b0}};
   localparam logic [N-1:0]  ONE_N    = {{(N-1){1'b0}}, 1'b1};
   localparam logic [N-1:0]  MAX_POS  = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0]  MAX_NEG  = {1'b1, {(N-2){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_LOAD = CW'(DW);
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DIVIDE = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   // Magnitude as unsigned; the most negative value maps to 2^(N-1)
   function automatic logic [N-1:0] f_mag(input logic [N-1:0] v);
      if (v[N-1]) begin
         f_mag = ~v + ONE_N;
      end else begin
         f_mag = v;
      end
   endfunction

   state_t          r_state;
   state_t          w_state_nx;
   logic            r_sign;
   logic [N-1:0]    r_bmag;
   logic [DW-1:0]   r_div;
   logic [N-1:0]    r_rem;
   logic [CW-1:0]   r_cnt;
   logic            r_busy;
   logic            r_done;
   logic [N-1:0]    r_result;
   logic            r_div_zero;

   logic            w_a_zero;
   logic            w_b_zero;
   logic            w_short;
   logic [N:0]      w_rem_sh;
   logic            w_ge;
   logic [N-1:0]    w_rem_sub;
   logic            w_q_over;
   logic            w_busy_nx;
   logic            w_done_nx;
   logic [N-1:0]    w_result_nx;
   logic            w_div_zero_nx;

   assign w_a_zero  = (i_a == ZERO_N);
   assign w_b_zero  = (i_b == ZERO_N);
   assign w_short   = w_a_zero | w_b_zero;
   assign w_rem_sh  = {r_rem, r_div[DW-1]};
   assign w_ge      = (w_rem_sh >= {1'b0, r_bmag});
   // Remainder after a successful subtract is below |B|, so N bits suffice
   assign w_rem_sub = w_rem_sh[N-1:0] - r_bmag;
   assign w_q_over  = |r_div[DW-1:N-1];

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start && !w_short) begin
               w_state_nx = S_DIVIDE;
            end else begin
               w_state_nx = S_IDLE;
            end
         end
         S_DIVIDE: begin
            if (r_cnt == CNT_ONE) begin
               w_state_nx = S_FINISH;
            end else begin
               w_state_nx = S_DIVIDE;
            end
         end
         S_FINISH: w_state_nx = S_IDLE;
         default:  w_state_nx = S_IDLE;
      endcase
   end

   // Output logic: next values for the registered outputs
   always_comb begin
      w_busy_nx     = (w_state_nx != S_IDLE);
      w_done_nx     = 1'b0;
      w_result_nx   = r_result;
      w_div_zero_nx = r_div_zero;
      case (r_state)
         S_IDLE: begin
            if (i_start && w_b_zero) begin
               w_done_nx     = 1'b1;
               w_div_zero_nx = 1'b1;
               if (w_a_zero) begin
                  w_result_nx = ZERO_N;
               end else if (i_a[N-1]) begin
                  w_result_nx = MAX_NEG;
               end else begin
                  w_result_nx = MAX_POS;
               end
            end else if (i_start && w_a_zero) begin
               w_done_nx     = 1'b1;
               w_div_zero_nx = 1'b0;
               w_result_nx   = ZERO_N;
            end else begin
               w_done_nx = 1'b0;
            end
         end
         S_FINISH: begin
            w_done_nx     = 1'b1;
            w_div_zero_nx = 1'b0;
            if (w_q_over) begin
               w_result_nx = r_sign ? MAX_NEG : MAX_POS;
            end else if (r_sign) begin
               w_result_nx = ~r_div[N-1:0] + ONE_N;
            end else begin
               w_result_nx = r_div[N-1:0];
            end
         end
         default: begin
            w_done_nx = 1'b0;
         end
      endcase
   end

   // Output registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_result   <= ZERO_N;
         r_div_zero <= 1'b0;
      end else begin
         r_busy     <= w_busy_nx;
         r_done     <= w_done_nx;
         r_result   <= w_result_nx;
         r_div_zero <= w_div_zero_nx;
      end
   end

   // Datapath: operand capture and one restoring iteration per DIVIDE cycle
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sign <= 1'b0;
         r_bmag <= ZERO_N;
         r_div  <= {DW{1'b0}};
         r_rem  <= ZERO_N;
         r_cnt  <= {CW{1'b0}};
      end else if (r_state == S_IDLE && i_start && !w_short) begin
         r_sign <= i_a[N-1] ^ i_b[N-1];
         r_bmag <= f_mag(i_b);
         r_div  <= {f_mag(i_a), {FRAC{1'b0}}};
         r_rem  <= ZERO_N;
         r_cnt  <= CNT_LOAD;
      end else if (r_state == S_DIVIDE) begin
         r_rem  <= w_ge ? w_rem_sub : w_rem_sh[N-1:0];
         r_div  <= {r_div[DW-2:0], w_ge};
         r_cnt  <= r_cnt - CNT_ONE;
      end else begin
         r_cnt  <= r_cnt;
      end
   end

   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_result   = r_result;
   assign o_div_zero = r_div_zero;

endmodule
